// File: rtl/dcache_controller_pkg.sv
// Shared types, geometry and address-field helpers for the direct-mapped data cache.
package dcache_controller_pkg;

    localparam int unsigned INDEX_W    = 4;
    localparam int unsigned LINE_W     = 256;
    localparam int unsigned OFFSET_W   = 5;
    localparam int unsigned WORD_SEL_W = 3;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned TAG_W      = 32 - INDEX_W - OFFSET_W;
    localparam int unsigned NUM_LINES  = 1 << INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
        return addr[31:32-TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [WORD_SEL_W-1:0] addr_word(input logic [31:0] addr);
        return addr[2 +: WORD_SEL_W];
    endfunction

    function automatic logic [31:0] line_addr(input logic [TAG_W-1:0] tag,
                                              input logic [INDEX_W-1:0] index);
        return {tag, index, {OFFSET_W{1'b0}}};
    endfunction

    function automatic logic [WORD_W-1:0] line_word(input logic [LINE_W-1:0] line,
                                                    input logic [WORD_SEL_W-1:0] sel);
        return line[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_controller_if.sv
// MEM-stage request/response and 256-bit memory bus seen by the data cache.
interface dcache_controller_if;
    import dcache_controller_pkg::*;

    logic              cpu_req_i;
    logic              cpu_write_i;
    logic [31:0]       cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [31:0]       mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

endinterface

// File: rtl/dcache_line_array.sv
// Valid/dirty/tag/data storage: combinational read, synchronous line fill and word write.
module dcache_line_array
    import dcache_controller_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [INDEX_W-1:0]    rd_index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [LINE_W-1:0]     rd_line,
    input  logic                  fill_en,
    input  logic [INDEX_W-1:0]    fill_index,
    input  logic [TAG_W-1:0]      fill_tag,
    input  logic [LINE_W-1:0]     fill_line,
    input  logic                  wr_en,
    input  logic [INDEX_W-1:0]    wr_index,
    input  logic [WORD_SEL_W-1:0] wr_sel,
    input  logic [WORD_W-1:0]     wr_word
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    assign rd_valid = valid_q[rd_index];
    assign rd_dirty = dirty_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_line  = data_q[rd_index];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            if (fill_en) begin
                valid_q[fill_index] <= 1'b1;
                dirty_q[fill_index] <= 1'b0;
            end
            if (wr_en) begin
                dirty_q[wr_index] <= 1'b1;
            end
        end
    end

    // Tag and data survive reset; only the valid bits decide whether they are used.
    always_ff @(posedge clk_i) begin
        if (fill_en) begin
            tag_q[fill_index]  <= fill_tag;
            data_q[fill_index] <= fill_line;
        end
        if (wr_en) begin
            data_q[wr_index][wr_sel*WORD_W +: WORD_W] <= wr_word;
        end
    end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller for the MEM stage.
module dcache_controller
    import dcache_controller_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    dcache_controller_if.slave  bus
);

    state_e               state_q;
    logic [TAG_W-1:0]     lat_tag_q;
    logic [INDEX_W-1:0]   lat_index_q;
    logic                 mem_enable_q;
    logic                 mem_write_q;
    logic [31:0]          mem_addr_q;
    logic [LINE_W-1:0]    mem_data_q;

    logic [TAG_W-1:0]      req_tag;
    logic [INDEX_W-1:0]    req_index;
    logic [WORD_SEL_W-1:0] req_sel;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [LINE_W-1:0]     rd_line;
    logic                  hit;
    logic                  fill_en;
    logic                  wr_en;
    logic                  unused_addr_bits;

    assign req_tag          = addr_tag(bus.cpu_addr_i);
    assign req_index        = addr_index(bus.cpu_addr_i);
    assign req_sel          = addr_word(bus.cpu_addr_i);
    assign unused_addr_bits = ^bus.cpu_addr_i[1:0];

    assign hit     = bus.cpu_req_i & rd_valid & (rd_tag == req_tag);
    assign wr_en   = (state_q == IDLE) & hit & bus.cpu_write_i;
    assign fill_en = (state_q == ALLOCATE) & mem_enable_q & bus.mem_ack_i;

    dcache_line_array u_lines (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .rd_index   (req_index),
        .rd_valid   (rd_valid),
        .rd_dirty   (rd_dirty),
        .rd_tag     (rd_tag),
        .rd_line    (rd_line),
        .fill_en    (fill_en),
        .fill_index (lat_index_q),
        .fill_tag   (lat_tag_q),
        .fill_line  (bus.mem_data_i),
        .wr_en      (wr_en),
        .wr_index   (req_index),
        .wr_sel     (req_sel),
        .wr_word    (bus.cpu_data_i)
    );

    always_comb begin
        bus.cpu_stall_o = 1'b1;
        bus.cpu_data_o  = '0;
        if (state_q == IDLE) begin
            bus.cpu_stall_o = bus.cpu_req_i & ~hit;
            if (hit && !bus.cpu_write_i) begin
                bus.cpu_data_o = line_word(rd_line, req_sel);
            end
        end
    end

    assign bus.mem_enable_o = mem_enable_q;
    assign bus.mem_write_o  = mem_write_q;
    assign bus.mem_addr_o   = mem_addr_q;
    assign bus.mem_data_o   = mem_data_q;

    // Stores are not latched: the held request replays as a write hit once the line is filled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            lat_tag_q    <= '0;
            lat_index_q  <= '0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req_i && !hit) begin
                        lat_tag_q    <= req_tag;
                        lat_index_q  <= req_index;
                        mem_enable_q <= 1'b1;
                        if (rd_valid && rd_dirty) begin
                            state_q     <= WRITEBACK;
                            mem_write_q <= 1'b1;
                            mem_addr_q  <= line_addr(rd_tag, req_index);
                            mem_data_q  <= rd_line;
                        end else begin
                            state_q     <= ALLOCATE;
                            mem_write_q <= 1'b0;
                            mem_addr_q  <= line_addr(req_tag, req_index);
                            mem_data_q  <= '0;
                        end
                    end
                end
                WRITEBACK: begin
                    // Enable drops for one cycle after the ack before the fetch is issued.
                    if (bus.mem_ack_i) begin
                        state_q      <= ALLOCATE;
                        mem_enable_q <= 1'b0;
                        mem_write_q  <= 1'b0;
                        mem_addr_q   <= '0;
                        mem_data_q   <= '0;
                    end
                end
                ALLOCATE: begin
                    if (mem_enable_q && bus.mem_ack_i) begin
                        state_q      <= IDLE;
                        mem_enable_q <= 1'b0;
                        mem_addr_q   <= '0;
                    end else if (!mem_enable_q) begin
                        mem_enable_q <= 1'b1;
                        mem_write_q  <= 1'b0;
                        mem_addr_q   <= line_addr(lat_tag_q, lat_index_q);
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    mem_enable_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed vector table, corner sequences, random traffic.
module tb_dcache_controller;

    localparam int LAT = 10;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    dcache_controller_if bus();

    dcache_controller dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- flat backing memory ----------------
    bit [255:0] backing [bit [26:0]];

    function automatic bit [255:0] get_line(input bit [26:0] la);
        bit [255:0] l;
        if (backing.exists(la)) return backing[la];
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = {5'b0, la} ^ (32'h5A00_0000 + w * 32'h0101_0101);
        return l;
    endfunction

    function automatic bit [31:0] word_at(input bit [31:0] a);
        bit [255:0] l;
        int w;
        l = get_line(a[31:5]);
        w = int'(a[4:2]);
        return l[w*32 +: 32];
    endfunction

    // ---------------- memory responder ----------------
    typedef struct { bit wr; bit [31:0] addr; } op_t;
    op_t ops[$];
    bit  mute = 0;
    bit  pend = 0;
    bit  aband = 0;
    int  cnt = 0;
    int  proto_err = 0;
    bit [31:0]  p_addr;
    bit         p_wr;
    bit [255:0] p_data;

    initial begin
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
    end

    always @(negedge clk_i) begin
        if (bus.mem_ack_i) begin
            bus.mem_ack_i = 1'b0;
            if (!aband) begin
                if (bus.mem_enable_o) proto_err++;
                ops.push_back('{p_wr, p_addr});
                if (p_wr) backing[p_addr[31:5]] = p_data;
            end
            pend  = 0;
            aband = 0;
        end else if (pend) begin
            if (!bus.mem_enable_o) aband = 1;
            else if (!aband && (bus.mem_addr_o !== p_addr || bus.mem_write_o !== p_wr ||
                                (p_wr && bus.mem_data_o !== p_data))) proto_err++;
            cnt++;
            if (cnt == LAT) begin
                bus.mem_ack_i = 1'b1;
                if (!p_wr) bus.mem_data_i = get_line(p_addr[31:5]);
            end
        end else if (bus.mem_enable_o && !mute) begin
            pend   = 1;
            cnt    = 1;
            p_addr = bus.mem_addr_o;
            p_wr   = bus.mem_write_o;
            p_data = bus.mem_data_o;
            if (bus.mem_addr_o[4:0] != 5'd0) proto_err++;
        end
    end

    // ---------------- CPU-side access ----------------
    task automatic access(input bit wr, input bit [31:0] a, input bit [31:0] d,
                          output int stalls, output bit [31:0] rd);
        @(negedge clk_i);
        bus.cpu_req_i   = 1'b1;
        bus.cpu_write_i = wr;
        bus.cpu_addr_i  = a;
        bus.cpu_data_i  = d;
        stalls = 0;
        #1;
        while (bus.cpu_stall_o === 1'b1) begin
            stalls++;
            if (stalls > 200) begin
                failures++;
                checks++;
                $display("FAIL stall_timeout addr=%0h actual=stuck required=release", a);
                break;
            end
            @(negedge clk_i);
            #1;
        end
        rd = bus.cpu_data_o;
        @(posedge clk_i);
        #1 bus.cpu_req_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.cpu_req_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_stall"}, bus.cpu_stall_o, 1'b0);
        check({tag, "_enable"}, bus.mem_enable_o, 1'b0);
        check({tag, "_write"}, bus.mem_write_o, 1'b0);
        check({tag, "_maddr"}, bus.mem_addr_o, 32'h0);
        check({tag, "_mdata"}, bus.mem_data_o, 256'h0);
        check({tag, "_rdata"}, bus.cpu_data_o, 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        bit wr; bit [31:0] addr; bit [31:0] wdata;
        int exp_stall; bit chk; bit [31:0] exp_data;
        int nops; bit op0_wr; bit [31:0] op0_addr; bit op1_wr; bit [31:0] op1_addr;
    } vec_t;
    vec_t vt[$];

    // random-phase reference: which line each index holds, plus every stored word
    bit        m_valid [16];
    bit        m_dirty [16];
    bit [22:0] m_tag   [16];
    bit [31:0] gold    [bit [31:0]];

    initial begin
        int         st;
        bit [31:0]  rd;
        bit [31:0]  snap_addr;
        bit [255:0] snap_data, l;
        int         changes, bad;

        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         st;
        bit [31:0]  rd;
        bit [31:0]  snap_addr;
        bit [255:0] snap_data, l;
        int         changes, bad;

        bus.cpu_req_i = 0; bus.cpu_write_i = 0; bus.cpu_addr_i = 0; bus.cpu_data_i = 0;
        rst_i = 1'b1;

        l = get_line(27'h8);
        l[63:32] = 32'hDEAD_BEEF;
        backing[27'h8] = l;

        vt.push_back('{0, 32'h104, 0, 11, 1, 32'hDEAD_BEEF, 1, 0, 32'h100, 0, 0});
        vt.push_back('{1, 32'h108, 32'h1234_5678, 0, 0, 0, 0, 0, 0, 0, 0});
        vt.push_back('{0, 32'h108, 0, 0, 1, 32'h1234_5678, 0, 0, 0, 0, 0});
        vt.push_back('{0, 32'h300, 0, 22, 1, word_at(32'h300), 2, 1, 32'h100, 0, 32'h300});
        vt.push_back('{1, 32'h40, 32'hA5A5_A5A5, 11, 0, 0, 1, 0, 32'h40, 0, 0});
        vt.push_back('{0, 32'h40, 0, 0, 1, 32'hA5A5_A5A5, 0, 0, 0, 0, 0});
        vt.push_back('{0, 32'h440, 0, 22, 1, word_at(32'h440), 2, 1, 32'h40, 0, 32'h440});

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1 check_quiet("reset");

        foreach (vt[i]) begin
            ops.delete();
            access(vt[i].wr, vt[i].addr, vt[i].wdata, st, rd);
            repeat (2) @(negedge clk_i);
            check($sformatf("v%0d_stall", i), st, vt[i].exp_stall);
            if (vt[i].chk) check($sformatf("v%0d_data", i), rd, vt[i].exp_data);
            check($sformatf("v%0d_nops", i), ops.size(), vt[i].nops);
            if (vt[i].nops > 0 && ops.size() > 0) begin
                check($sformatf("v%0d_op0_wr", i), ops[0].wr, vt[i].op0_wr);
                check($sformatf("v%0d_op0_addr", i), ops[0].addr, vt[i].op0_addr);
            end
            if (vt[i].nops > 1 && ops.size() > 1) begin
                check($sformatf("v%0d_op1_wr", i), ops[1].wr, vt[i].op1_wr);
                check($sformatf("v%0d_op1_addr", i), ops[1].addr, vt[i].op1_addr);
            end
        end
        check("wb_word2_0x108", word_at(32'h108), 32'h1234_5678);
        check("wb_word0_0x40", word_at(32'h40), 32'hA5A5_A5A5);

        // reset in the middle of a write-back
        access(1, 32'h300, 32'hCAFE_0001, st, rd);
        check("dirty_store_stall", st, 0);
        ops.delete();
        @(negedge clk_i);
        bus.cpu_req_i = 1; bus.cpu_write_i = 0; bus.cpu_addr_i = 32'h500;
        repeat (4) @(negedge clk_i);
        #1;
        check("wb_enable", bus.mem_enable_o, 1'b1);
        check("wb_write", bus.mem_write_o, 1'b1);
        check("wb_addr", bus.mem_addr_o, 32'h300);
        check("wb_data_w0", bus.mem_data_o[31:0], 32'hCAFE_0001);
        @(negedge clk_i);
        rst_i = 1'b1;
        bus.cpu_req_i = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1 check_quiet("midrst");
        bad = 0;
        repeat (15) begin
            @(negedge clk_i);
            #1 if (bus.mem_enable_o || bus.cpu_stall_o) bad++;
        end
        check("late_ack_ignored", bad, 0);
        check("late_ack_no_ops", ops.size(), 0);
        access(0, 32'h108, 0, st, rd);
        check("postrst_stall", st, 11);
        check("postrst_data", rd, 32'h1234_5678);
        check("postrst_nops", ops.size(), 1);

        // memory never acks
        mute = 1;
        ops.delete();
        @(negedge clk_i);
        bus.cpu_req_i = 1; bus.cpu_write_i = 0; bus.cpu_addr_i = 32'h700;
        @(negedge clk_i);
        #1;
        check("hang_enable", bus.mem_enable_o, 1'b1);
        check("hang_addr", bus.mem_addr_o, 32'h700);
        snap_addr = bus.mem_addr_o;
        snap_data = bus.mem_data_o;
        changes = 0;
        repeat (120) begin
            @(negedge clk_i);
            #1 if (!bus.cpu_stall_o || !bus.mem_enable_o || bus.mem_write_o ||
                   bus.mem_addr_o !== snap_addr || bus.mem_data_o !== snap_data) changes++;
        end
        check("hang_hold", changes, 0);
        do_reset();
        mute = 0;
        check("hang_no_ops", ops.size(), 0);
        check("proto_directed", proto_err, 0);

        // random traffic against reference
        for (int i = 0; i < 16; i++) begin m_valid[i] = 0; m_dirty[i] = 0; m_tag[i] = 0; end
        gold.delete();
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk_i);
                #1 check("rnd_idle_quiet", {bus.cpu_stall_o, bus.mem_enable_o, bus.cpu_data_o}, 34'h0);
            end else begin
                bit        wr;
                bit [3:0]  idx;
                bit [22:0] tg;
                bit [31:0] a, d;
                int        exp_st;
                wr  = 1'($urandom_range(0, 1));
                idx = 4'($urandom_range(0, 3));
                tg  = 23'($urandom_range(0, 3));
                a   = tg * 512 + idx * 32 + $urandom_range(0, 7) * 4;
                d   = $urandom;
                if (m_valid[idx] && m_tag[idx] == tg) exp_st = 0;
                else if (m_valid[idx] && m_dirty[idx]) exp_st = 2 * LAT + 2;
                else exp_st = LAT + 1;
                access(wr, a, d, st, rd);
                check($sformatf("rnd%0d_stall", n), st, exp_st);
                if (!wr) check($sformatf("rnd%0d_data_%0h", n, a), rd,
                               gold.exists(a) ? gold[a] : word_at(a));
                if (exp_st != 0) begin
                    m_valid[idx] = 1; m_tag[idx] = tg; m_dirty[idx] = 0;
                end
                if (wr) begin
                    m_dirty[idx] = 1;
                    gold[a] = d;
                end
            end
        end
        repeat (3) @(negedge clk_i);
        check("proto_total", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
